// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
//   Two-port (icache refill / data load-store) arbiter onto one memory port.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 256,
    parameter int CNT_W      = 9
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        p0_valid_i,
    input  logic [31:0] p0_addr_i,
    output logic        p0_ready_o,
    output logic [31:0] p0_rdata_o,
    output logic        p0_err_o,
    input  logic        p1_valid_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    input  logic [3:0]  p1_wstrb_i,
    output logic        p1_ready_o,
    output logic [31:0] p1_rdata_o,
    output logic        p1_err_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic             c_wdog_en = (TIMEOUT != 0);

    state_t            state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_valid_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              p0_ready_q;
    logic [31:0]       p0_rdata_q;
    logic              p0_err_q;
    logic              p1_ready_q;
    logic [31:0]       p1_rdata_q;
    logic              p1_err_q;

    logic              grant_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              w_timeout_hit;
    logic              w_resp_done;
    logic [31:0]       w_resp_data;
    logic              w_resp_err;

    // Port 1 wins only when alone, or on a tie in round-robin mode after port 0.
    always_comb begin
        grant_d = 1'b0;
        if (p0_valid_i && p1_valid_i) begin
            grant_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else if (p1_valid_i) begin
            grant_d = 1'b1;
        end
    end

    assign cnt_d         = cnt_q + 1'b1;
    assign w_timeout_hit = c_wdog_en && (cnt_d == c_timeout);
    assign w_resp_done   = mem_ready_i || w_timeout_hit;
    assign w_resp_data   = mem_ready_i ? mem_rdata_i : 32'h0;
    assign w_resp_err    = !mem_ready_i;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'h0;
            p0_ready_q   <= 1'b0;
            p0_rdata_q   <= 32'h0;
            p0_err_q     <= 1'b0;
            p1_ready_q   <= 1'b0;
            p1_rdata_q   <= 32'h0;
            p1_err_q     <= 1'b0;
        end else begin
            p0_ready_q <= 1'b0;
            p1_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (p0_valid_i || p1_valid_i) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        mem_valid_q  <= 1'b1;
                        mem_addr_q   <= grant_d ? p1_addr_i  : p0_addr_i;
                        mem_wdata_q  <= grant_d ? p1_wdata_i : 32'h0;
                        mem_wstrb_q  <= grant_d ? p1_wstrb_i : 4'h0;
                        cnt_q        <= '0;
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_resp_done) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= S_DONE;
                        if (grant_q) begin
                            p1_ready_q <= 1'b1;
                            p1_rdata_q <= w_resp_data;
                            p1_err_q   <= w_resp_err;
                        end else begin
                            p0_ready_q <= 1'b1;
                            p0_rdata_q <= w_resp_data;
                            p0_err_q   <= w_resp_err;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign p0_ready_o  = p0_ready_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p0_err_o    = p0_err_q;
    assign p1_ready_o  = p1_ready_q;
    assign p1_rdata_o  = p1_rdata_q;
    assign p1_err_o    = p1_err_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
//   Directed bench: round-robin/timeout instance plus a fixed-priority instance.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        p0_valid;
    logic [31:0] p0_addr;
    logic        p1_valid;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        p0_ready, p0_err, p1_ready, p1_err, mem_valid;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        b_p0_ready, b_p0_err, b_p1_ready, b_p1_err, b_mem_valid;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wstrb;
    logic        b_mem_ready;
    logic [31:0] b_mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8), .CNT_W(4)) u_dut_rr (
        .clk(clk), .resetn(resetn),
        .p0_valid_i(p0_valid), .p0_addr_i(p0_addr),
        .p0_ready_o(p0_ready), .p0_rdata_o(p0_rdata), .p0_err_o(p0_err),
        .p1_valid_i(p1_valid), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_wstrb_i(p1_wstrb),
        .p1_ready_o(p1_ready), .p1_rdata_o(p1_rdata), .p1_err_o(p1_err),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.FIXED_PRIO(1), .TIMEOUT(8), .CNT_W(4)) u_dut_fp (
        .clk(clk), .resetn(resetn),
        .p0_valid_i(p0_valid), .p0_addr_i(p0_addr),
        .p0_ready_o(b_p0_ready), .p0_rdata_o(b_p0_rdata), .p0_err_o(b_p0_err),
        .p1_valid_i(p1_valid), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_wstrb_i(p1_wstrb),
        .p1_ready_o(b_p1_ready), .p1_rdata_o(b_p1_rdata), .p1_err_o(b_p1_err),
        .mem_valid_o(b_mem_valid), .mem_ready_i(b_mem_ready), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_wstrb_o(b_mem_wstrb), .mem_rdata_i(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory for the fixed-priority instance.
    initial begin
        b_mem_ready = 1'b0;
        b_mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            b_mem_ready = b_mem_valid;
            b_mem_rdata = b_mem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int pulses;
        logic exp_port;
        logic [31:0] exp_addr;

        resetn = 1'b0; p0_valid = 1'b0; p0_addr = 32'h0;
        p1_valid = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_wstrb = 4'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;

        // Reset: three cycles low, everything zero.
        tick(); tick(); tick();
        check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_mem_addr",  mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_p0_ready",  {31'h0, p0_ready}, 32'h0);
        check("rst_p1_ready",  {31'h0, p1_ready}, 32'h0);
        check("rst_p0_rdata",  p0_rdata, 32'h0);
        check("rst_p1_err",    {31'h0, p1_err}, 32'h0);

        p0_valid = 1'b1; p0_addr = 32'h100; resetn = 1'b1;
        tick();
        check("rel_mem_valid", {31'h0, mem_valid}, 32'h1);
        check("rel_mem_addr",  mem_addr, 32'h100);
        check("rel_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        check("rel_p0_ready", {31'h0, p0_ready}, 32'h1);
        mem_ready = 1'b0; p0_valid = 1'b0;
        tick();

        // Single read; port 1 strobes must not leak into a port 0 request.
        p0_valid = 1'b1; p0_addr = 32'h40; p1_wstrb = 4'hF; p1_wdata = 32'hFFFF_FFFF;
        tick();
        check("rd_mem_addr",  mem_addr, 32'h40);
        check("rd_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rd_p0_ready_early", {31'h0, p0_ready}, 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("rd_p0_ready", {31'h0, p0_ready}, 32'h1);
        check("rd_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
        check("rd_p0_err",   {31'h0, p0_err}, 32'h0);
        check("rd_p1_ready", {31'h0, p1_ready}, 32'h0);
        check("rd_mem_valid_drop", {31'h0, mem_valid}, 32'h0);
        mem_ready = 1'b0; p0_valid = 1'b0; p1_wstrb = 4'h0; p1_wdata = 32'h0;
        tick();
        check("rd_p0_ready_pulse", {31'h0, p0_ready}, 32'h0);
        check("rd_p0_rdata_hold",  p0_rdata, 32'hDEAD_BEEF);

        // Stray mem_ready in IDLE.
        mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        tick();
        check("idle_ready_p0", {31'h0, p0_ready}, 32'h0);
        check("idle_ready_mv", {31'h0, mem_valid}, 32'h0);
        check("idle_ready_rdata", p0_rdata, 32'hDEAD_BEEF);
        mem_ready = 1'b0;

        // Fresh reset so last_grant starts at 1; both ports contend continuously.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        p0_valid = 1'b1; p0_addr = 32'h1000;
        p1_valid = 1'b1; p1_addr = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            exp_port = i[0];
            exp_addr = exp_port ? 32'h2000 : 32'h1000;
            tick();
            check($sformatf("rr%0d_addr", i), mem_addr, exp_addr);
            check($sformatf("fp%0d_addr", i), b_mem_addr, 32'h1000);
            mem_ready = 1'b1; mem_rdata = 32'hA000_0000 | 32'(i);
            tick();
            check($sformatf("rr%0d_p0_ready", i), {31'h0, p0_ready}, {31'h0, ~exp_port});
            check($sformatf("rr%0d_p1_ready", i), {31'h0, p1_ready}, {31'h0, exp_port});
            check($sformatf("rr%0d_rdata", i), exp_port ? p1_rdata : p0_rdata, 32'hA000_0000 | 32'(i));
            check($sformatf("fp%0d_p0_ready", i), {31'h0, b_p0_ready}, 32'h1);
            check($sformatf("fp%0d_p1_ready", i), {31'h0, b_p1_ready}, 32'h0);
            mem_ready = 1'b0;
            if (i == 3) begin
                p0_valid = 1'b0; p1_valid = 1'b0;
            end
            tick();
        end

        // Store with wait states: request fields stable until mem_ready.
        p1_valid = 1'b1; p1_addr = 32'h200; p1_wdata = 32'h1234_5678; p1_wstrb = 4'b0011;
        tick();
        for (int w = 0; w < 3; w++) begin
            check($sformatf("st%0d_mem_valid", w), {31'h0, mem_valid}, 32'h1);
            check($sformatf("st%0d_mem_addr", w),  mem_addr, 32'h200);
            check($sformatf("st%0d_mem_wdata", w), mem_wdata, 32'h1234_5678);
            check($sformatf("st%0d_mem_wstrb", w), {28'h0, mem_wstrb}, 32'h3);
            if (w < 2) tick();
        end
        mem_ready = 1'b1; mem_rdata = 32'h0;
        tick();
        check("st_p1_ready", {31'h0, p1_ready}, 32'h1);
        check("st_p1_err",   {31'h0, p1_err}, 32'h0);
        check("st_p0_ready", {31'h0, p0_ready}, 32'h0);
        mem_ready = 1'b0; p1_valid = 1'b0; p1_wstrb = 4'h0;
        tick();

        // Watchdog: memory never answers.
        p0_valid = 1'b1; p0_addr = 32'h300;
        tick();
        n = 0;
        while (mem_valid && n < 20) begin
            n++;
            tick();
        end
        check("to_valid_cycles", 32'(n), 32'd8);
        check("to_p0_ready", {31'h0, p0_ready}, 32'h1);
        check("to_p0_err",   {31'h0, p0_err}, 32'h1);
        check("to_p0_rdata", p0_rdata, 32'h0);
        p0_valid = 1'b0;
        tick();
        check("to_p0_err_hold", {31'h0, p0_err}, 32'h1);

        // Normal read after a timeout clears err.
        p0_valid = 1'b1; p0_addr = 32'h44;
        tick();
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        check("rec_p0_ready", {31'h0, p0_ready}, 32'h1);
        check("rec_p0_err",   {31'h0, p0_err}, 32'h0);
        check("rec_p0_rdata", p0_rdata, 32'hCAFE_F00D);
        mem_ready = 1'b0; p0_valid = 1'b0;
        tick();

        // Reset during a REQ wait, with mem_ready arriving on the reset edge.
        p1_valid = 1'b1; p1_addr = 32'h500;
        tick();
        tick();
        check("mr_mem_valid_pre", {31'h0, mem_valid}, 32'h1);
        resetn = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        check("mr_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("mr_p1_ready",  {31'h0, p1_ready}, 32'h0);
        check("mr_p1_rdata",  p1_rdata, 32'h0);
        resetn = 1'b1; p1_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            mem_ready = (c == 2);
            tick();
            if (p0_ready || p1_ready) pulses++;
        end
        mem_ready = 1'b0;
        check("mr_no_ready_pulse", 32'(pulses), 32'd0);
        check("mr_idle_mem_valid", {31'h0, mem_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
